// File: rtl/int_to_float_conv.sv
// -----------------------------------------------------------------------------
// int_to_float_conv
//   Sequential integer to floating-point converter. A signed or unsigned
//   integer is turned into {sign, biased exponent, fraction} with one of four
//   rounding modes. Operation runs IDLE -> LOAD -> NORM -> ROUND -> PACK and
//   reports completion with a one-cycle done strobe.
//
// Configuration macro:
//   INT_TO_FLOAT_CONV_FAST_NORM_EN - when defined, NORM uses a leading-zero
//   count plus barrel shift and takes one cycle. Otherwise NORM shifts one bit
//   per cycle. Results are identical in both builds.
//
// Ports:
//   clk            - clock, all state changes on rising edge
//   reset_n_i      - asynchronous active-low reset
//   a_value_i      - integer operand, sampled on the accepted exec cycle
//   signed_i       - 1 = two's complement operand, 0 = unsigned
//   round_mode_i   - 0 RNE, 1 RTZ, 2 RDN (toward -inf), 3 RUP (toward +inf)
//   exec_strobe_i  - start request, honoured only in IDLE
//   z_value_o      - result {sign, exponent, fraction}, held until next result
//   inexact_o      - discarded bits were nonzero, updated with z_value_o
//   busy_o         - high in every state except IDLE
//   done_strobe_o  - one-cycle pulse while the new result is presented
// -----------------------------------------------------------------------------
module int_to_float_conv #(
  parameter int INT_WIDTH = 32,
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                         clk,
  input  logic                         reset_n_i,
  input  logic [INT_WIDTH-1:0]         a_value_i,
  input  logic                         signed_i,
  input  logic [1:0]                   round_mode_i,
  input  logic                         exec_strobe_i,
  output logic [EXP_WIDTH+MAN_WIDTH:0] z_value_o,
  output logic                         inexact_o,
  output logic                         busy_o,
  output logic                         done_strobe_o
);

  // Magnitude padded below with MAN_WIDTH+3 zeros so mantissa, guard, round
  // and sticky always exist even for narrow operands.
  localparam int XW = INT_WIDTH + MAN_WIDTH + 3;
  localparam logic [EXP_WIDTH-1:0] BIAS    = EXP_WIDTH'((2 ** (EXP_WIDTH - 1)) - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_TOP = EXP_WIDTH'(INT_WIDTH - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_ONE = {{(EXP_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [EXP_WIDTH-1:0] EXP_ZERO = {EXP_WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_NORM  = 3'd2,
    ST_ROUND = 3'd3,
    ST_PACK  = 3'd4
  } state_t;

  state_t                       r_state;
  logic [INT_WIDTH-1:0]         r_a;
  logic                         r_signed;
  logic [1:0]                   r_mode;
  logic                         r_sign;
  logic                         r_zero;
  logic [INT_WIDTH-1:0]         r_mag;
  logic [EXP_WIDTH-1:0]         r_exp;
  logic [MAN_WIDTH-1:0]         r_frac;
  logic                         r_inx;
  logic [EXP_WIDTH+MAN_WIDTH:0] r_z;
  logic                         r_inexact;
  logic                         r_busy;
  logic                         r_done;

  logic                         w_load_sign;
  logic [INT_WIDTH-1:0]         w_load_mag;
  logic [XW-1:0]                w_ext;
  logic [MAN_WIDTH:0]           w_mant;
  logic                         w_guard;
  logic                         w_round;
  logic                         w_sticky;
  logic                         w_inexact;
  logic                         w_inc;
  logic [MAN_WIDTH+1:0]         w_sum;
  logic                         w_carry;
  logic [MAN_WIDTH-1:0]         w_frac_rnd;

  // Sign and magnitude of the captured operand; negating the most negative
  // value wraps back onto itself, which is exactly 2^(INT_WIDTH-1) unsigned.
  always_comb begin
    w_load_sign = r_signed & r_a[INT_WIDTH-1];
    if (w_load_sign) begin
      w_load_mag = (~r_a) + {{(INT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      w_load_mag = r_a;
    end
  end

  // Rounding datapath working on the normalised magnitude.
  always_comb begin
    w_ext     = {r_mag, {(MAN_WIDTH+3){1'b0}}};
    w_mant    = w_ext[XW-1 -: MAN_WIDTH+1];
    w_guard   = w_ext[XW-MAN_WIDTH-2];
    w_round   = w_ext[XW-MAN_WIDTH-3];
    w_sticky  = |w_ext[XW-MAN_WIDTH-4:0];
    w_inexact = w_guard | w_round | w_sticky;
    case (r_mode)
      2'd0:    w_inc = w_guard & (w_round | w_sticky | w_mant[0]);
      2'd1:    w_inc = 1'b0;
      2'd2:    w_inc = r_sign & w_inexact;
      2'd3:    w_inc = (~r_sign) & w_inexact;
      default: w_inc = 1'b0;
    endcase
    w_sum   = {1'b0, w_mant} + {{(MAN_WIDTH+1){1'b0}}, w_inc};
    w_carry = w_sum[MAN_WIDTH+1];
    // On carry-out the sum is 10...0, so the fraction after renormalising
    // is the all-zero field just below the new leading one.
    if (w_carry) begin
      w_frac_rnd = w_sum[MAN_WIDTH:1];
    end else begin
      w_frac_rnd = w_sum[MAN_WIDTH-1:0];
    end
  end

`ifdef INT_TO_FLOAT_CONV_FAST_NORM_EN
  logic [EXP_WIDTH-1:0] w_lz;
  logic                 w_found;

  // Leading-zero count of the magnitude for single-cycle normalisation.
  always_comb begin
    w_lz    = EXP_ZERO;
    w_found = 1'b0;
    for (int i = INT_WIDTH - 1; i >= 0; i--) begin
      if (w_found) begin
        w_lz = w_lz;
      end else if (r_mag[i]) begin
        w_found = 1'b1;
      end else begin
        w_lz = w_lz + EXP_ONE;
      end
    end
  end
`endif

  // Conversion FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= ST_IDLE;
      r_a       <= {INT_WIDTH{1'b0}};
      r_signed  <= 1'b0;
      r_mode    <= 2'd0;
      r_sign    <= 1'b0;
      r_zero    <= 1'b0;
      r_mag     <= {INT_WIDTH{1'b0}};
      r_exp     <= EXP_ZERO;
      r_frac    <= {MAN_WIDTH{1'b0}};
      r_inx     <= 1'b0;
      r_z       <= {(EXP_WIDTH+MAN_WIDTH+1){1'b0}};
      r_inexact <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (exec_strobe_i) begin
            r_a      <= a_value_i;
            r_signed <= signed_i;
            r_mode   <= round_mode_i;
            r_busy   <= 1'b1;
            r_state  <= ST_LOAD;
          end else begin
            r_busy   <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_sign <= w_load_sign;
          r_mag  <= w_load_mag;
          r_exp  <= EXP_TOP;
          r_inx  <= 1'b0;
          if (w_load_mag == {INT_WIDTH{1'b0}}) begin
            r_zero  <= 1'b1;
            r_state <= ST_PACK;
          end else begin
            r_zero  <= 1'b0;
            r_state <= ST_NORM;
          end
        end
        ST_NORM: begin
`ifdef INT_TO_FLOAT_CONV_FAST_NORM_EN
          r_mag   <= r_mag << w_lz;
          r_exp   <= EXP_TOP - w_lz;
          r_state <= ST_ROUND;
`else
          if (r_mag[INT_WIDTH-1]) begin
            r_state <= ST_ROUND;
          end else begin
            r_mag <= {r_mag[INT_WIDTH-2:0], 1'b0};
            r_exp <= r_exp - EXP_ONE;
          end
`endif
        end
        ST_ROUND: begin
          r_frac  <= w_frac_rnd;
          r_exp   <= r_exp + {{(EXP_WIDTH-1){1'b0}}, w_carry};
          r_inx   <= w_inexact;
          r_state <= ST_PACK;
        end
        ST_PACK: begin
          if (r_zero) begin
            r_z       <= {(EXP_WIDTH+MAN_WIDTH+1){1'b0}};
            r_inexact <= 1'b0;
          end else begin
            r_z       <= {r_sign, r_exp + BIAS, r_frac};
            r_inexact <= r_inx;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign z_value_o     = r_z;
  assign inexact_o     = r_inexact;
  assign busy_o        = r_busy;
  assign done_strobe_o = r_done;

endmodule

// File: tb/tb_int_to_float_conv.sv
// -----------------------------------------------------------------------------
// tb_int_to_float_conv
//   Two converters: default 32/8/23 and a 16/5/10 instance for the sweep.
//   An arithmetic reference model predicts result, inexact flag and done
//   timing; one process compares every cycle. Directed vectors carry
//   hand-computed literal results and latencies.
// -----------------------------------------------------------------------------
module tb_int_to_float_conv;

`ifdef INT_TO_FLOAT_CONV_FAST_NORM_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_a = 32'd0;
  logic        s_a = 1'b0;
  logic [1:0]  m_a = 2'd0;
  logic        e_a = 1'b0;
  logic [31:0] z_a;
  logic        inx_a, busy_a, done_a;

  logic [15:0] a_b = 16'd0;
  logic        s_b = 1'b0;
  logic [1:0]  m_b = 2'd0;
  logic        e_b = 1'b0;
  logic [15:0] z_b;
  logic        inx_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int_to_float_conv #(.INT_WIDTH(32), .EXP_WIDTH(8), .MAN_WIDTH(23)) u_dut_a (
    .clk(clk), .reset_n_i(rst_n), .a_value_i(a_a), .signed_i(s_a),
    .round_mode_i(m_a), .exec_strobe_i(e_a), .z_value_o(z_a),
    .inexact_o(inx_a), .busy_o(busy_a), .done_strobe_o(done_a));

  int_to_float_conv #(.INT_WIDTH(16), .EXP_WIDTH(5), .MAN_WIDTH(10)) u_dut_b (
    .clk(clk), .reset_n_i(rst_n), .a_value_i(a_b), .signed_i(s_b),
    .round_mode_i(m_b), .exec_strobe_i(e_b), .z_value_o(z_b),
    .inexact_o(inx_b), .busy_o(busy_b), .done_strobe_o(done_b));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Cycles from accepting edge to the edge that raises done.
  function automatic int lat_of(input int lz);
    if (lz < 0) return 2;
    if (FAST) return 4;
    return 4 + lz;
  endfunction

  // Exact arithmetic reference: value = q * 2^(e-mw) + rem, rounded by mode.
  function automatic logic [63:0] ref_conv(input int iw, input int ew, input int mw,
                                           input logic [63:0] a_in, input logic sg,
                                           input logic [1:0] mode,
                                           output logic inx, output int lz);
    longint unsigned a, mag, q, rem, half, bias;
    int e;
    logic neg, inc;
    a   = a_in & ((64'd1 << iw) - 64'd1);
    neg = sg && (((a >> (iw - 1)) & 64'd1) != 64'd0);
    mag = neg ? ((64'd1 << iw) - a) : a;
    inx = 1'b0;
    lz  = -1;
    if (mag == 64'd0) return 64'd0;
    e = 0;
    while ((mag >> (e + 1)) != 64'd0) e++;
    lz = iw - 1 - e;
    if (e <= mw) begin
      q = mag << (mw - e); rem = 64'd0; half = 64'd1;
    end else begin
      q    = mag >> (e - mw);
      rem  = mag - (q << (e - mw));
      half = 64'd1 << (e - mw - 1);
    end
    inx = (rem != 64'd0);
    case (mode)
      2'd0:    inc = (rem > half) || ((rem == half) && q[0]);
      2'd1:    inc = 1'b0;
      2'd2:    inc = neg && inx;
      default: inc = !neg && inx;
    endcase
    q = q + (inc ? 64'd1 : 64'd0);
    if (q == (64'd1 << (mw + 1))) begin
      q = q >> 1;
      e++;
    end
    bias = (64'd1 << (ew - 1)) - 64'd1;
    return ((neg ? 64'd1 : 64'd0) << (ew + mw)) | ((64'(e) + bias) << mw)
           | (q & ((64'd1 << mw) - 64'd1));
  endfunction

  // Cycle-by-cycle scoreboard for both converters.
  logic        mb[2];
  int          mdue[2];
  logic [63:0] mz_exp[2], mz_last[2];
  logic        mi_exp[2], mi_last[2];

  initial begin
    for (int u = 0; u < 2; u++) begin
      mb[u] = 1'b0; mdue[u] = 0; mz_exp[u] = 64'd0; mz_last[u] = 64'd0;
      mi_exp[u] = 1'b0; mi_last[u] = 1'b0;
    end
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int u = 0; u < 2; u++) begin
        logic [63:0] av, az;
        logic sg, ex, ai, ab, ad, exp_done, accept, tinx;
        logic [1:0] md;
        int iw, ew, mw, tlz;
        if (u == 0) begin
          av = 64'(a_a); sg = s_a; md = m_a; ex = e_a; az = 64'(z_a);
          ai = inx_a; ab = busy_a; ad = done_a; iw = 32; ew = 8; mw = 23;
        end else begin
          av = 64'(a_b); sg = s_b; md = m_b; ex = e_b; az = 64'(z_b);
          ai = inx_b; ab = busy_b; ad = done_b; iw = 16; ew = 5; mw = 10;
        end
        if (!rst_n) begin
          mb[u] = 1'b0; mz_last[u] = 64'd0; mi_last[u] = 1'b0;
        end else begin
          exp_done = mb[u] && (cyc == mdue[u]);
          accept   = !mb[u] && ex;
          if (exp_done) begin
            mb[u] = 1'b0; mz_last[u] = mz_exp[u]; mi_last[u] = mi_exp[u];
          end
          if (accept) begin
            mz_exp[u] = ref_conv(iw, ew, mw, av, sg, md, tinx, tlz);
            mi_exp[u] = tinx;
            mb[u]     = 1'b1;
            mdue[u]   = cyc + lat_of(tlz);
          end
          chk($sformatf("u%0d_done", u), 64'(ad), 64'(exp_done));
        end
        chk($sformatf("u%0d_busy", u), 64'(ab), 64'(mb[u]));
        chk($sformatf("u%0d_z", u), az, mz_last[u]);
        chk($sformatf("u%0d_inexact", u), 64'(ai), 64'(mi_last[u]));
      end
    end
  end

  // Drive one exec pulse (called at a negedge); returns the accepting edge.
  task automatic go(input int u, input logic [31:0] a, input logic s,
                    input logic [1:0] m, output int k);
    if (u == 0) begin a_a = a; s_a = s; m_a = m; e_a = 1'b1; end
    else begin a_b = a[15:0]; s_b = s; m_b = m; e_b = 1'b1; end
    @(negedge clk);
    k = cyc;
    if (u == 0) begin e_a = 1'b0; a_a = ~a; s_a = ~s; end
    else begin e_b = 1'b0; a_b = ~a[15:0]; s_b = ~s; end
  endtask

  // Wait (bounded) for done; leaves caller at the negedge inside done cycle.
  task automatic waitd(input int u, input int k, output int lat);
    int n = 0;
    while (((u == 0) ? done_a : done_b) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("u%0d_done_seen", u), 64'((u == 0) ? done_a : done_b), 64'd1);
    lat = cyc - k;
  endtask

  task automatic dir32(input string nm, input logic [31:0] a, input logic s,
                       input logic [1:0] m, input logic [31:0] ez, input logic ei,
                       input int lz);
    int k, lat;
    go(0, a, s, m, k);
    waitd(0, k, lat);
    chk({nm, "_z"}, 64'(z_a), 64'(ez));
    chk({nm, "_inexact"}, 64'(inx_a), 64'(ei));
    chk({nm, "_latency"}, 64'(lat), 64'(lat_of(lz)));
  endtask

  task automatic run16(input logic [15:0] a, input logic s, input logic [1:0] m);
    int k, lat;
    go(1, {16'd0, a}, s, m, k);
    waitd(1, k, lat);
  endtask

  initial begin
    int k, lat, tlz;
    logic tinx;
    logic [15:0] specials [5];
    specials[0] = 16'h0000; specials[1] = 16'h0001; specials[2] = 16'h8000;
    specials[3] = 16'hFFFF; specials[4] = 16'h7FFF;

    // Pin the model with hand-derived values.
    chk("pin_a", ref_conv(32, 8, 23, 64'h12345678, 1'b1, 2'd0, tinx, tlz), 64'h4D91A2B4);
    chk("pin_a_inx", 64'(tinx), 64'd1);
    chk("pin_b", ref_conv(32, 8, 23, 64'hFFFFFFFF, 1'b0, 2'd0, tinx, tlz), 64'h4F800000);
    chk("pin_c", ref_conv(16, 5, 10, 64'h0001, 1'b0, 2'd0, tinx, tlz), 64'h3C00);
    chk("pin_d", ref_conv(16, 5, 10, 64'h8000, 1'b1, 2'd0, tinx, tlz), 64'hF800);
    chk("pin_e", ref_conv(16, 5, 10, 64'hFFFF, 1'b1, 2'd1, tinx, tlz), 64'hBC00);
    chk("pin_f", ref_conv(16, 5, 10, 64'hFFFF, 1'b0, 2'd0, tinx, tlz), 64'h7C00);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    dir32("one",      32'h00000001, 1'b1, 2'd0, 32'h3F800000, 1'b0, 31);
    dir32("zero",     32'h00000000, 1'b1, 2'd0, 32'h00000000, 1'b0, -1);
    dir32("minint_s", 32'h80000000, 1'b1, 2'd0, 32'hCF000000, 1'b0, 0);
    dir32("minint_u", 32'h80000000, 1'b0, 2'd0, 32'h4F000000, 1'b0, 0);
    dir32("neg_one",  32'hFFFFFFFF, 1'b1, 2'd0, 32'hBF800000, 1'b0, 31);
    dir32("rne_tie",  32'h01000001, 1'b1, 2'd0, 32'h4B800000, 1'b1, 7);
    dir32("rup",      32'h01000001, 1'b1, 2'd3, 32'h4B800001, 1'b1, 7);
    dir32("rtz",      32'h01000001, 1'b1, 2'd1, 32'h4B800000, 1'b1, 7);
    dir32("rdn_neg",  32'hFEFFFFFF, 1'b1, 2'd2, 32'hCB800001, 1'b1, 7);
    dir32("rne_odd",  32'h01000003, 1'b0, 2'd0, 32'h4B800002, 1'b1, 7);
    dir32("rdn_pos",  32'h01000003, 1'b0, 2'd2, 32'h4B800001, 1'b1, 7);
    dir32("carry",    32'hFFFFFFFF, 1'b0, 2'd0, 32'h4F800000, 1'b1, 0);
    dir32("rtz_max",  32'hFFFFFFFF, 1'b0, 2'd1, 32'h4F7FFFFF, 1'b1, 0);

    // Exec while busy is ignored; the first operand's result is delivered.
    go(0, 32'd3, 1'b1, 2'd0, k);
    @(negedge clk); @(negedge clk);
    a_a = 32'd5; s_a = 1'b0; e_a = 1'b1;
    @(negedge clk);
    e_a = 1'b0;
    waitd(0, k, lat);
    chk("busy_ignore_z", 64'(z_a), 64'h40400000);
    chk("busy_ignore_lat", 64'(lat), 64'(lat_of(30)));
    repeat (40) @(negedge clk);

    // Exec in the done cycle starts the next conversion.
    go(0, 32'h00000100, 1'b0, 2'd0, k);
    waitd(0, k, lat);
    chk("b2b_first_z", 64'(z_a), 64'h43800000);
    go(0, 32'd2, 1'b0, 2'd1, k);
    waitd(0, k, lat);
    chk("b2b_second_z", 64'(z_a), 64'h40000000);
    chk("b2b_second_lat", 64'(lat), 64'(lat_of(30)));
    repeat (40) @(negedge clk);

    // Reset while normalising clears outputs at once.
    go(0, 32'd1, 1'b1, 2'd0, k);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_z", 64'(z_a), 64'd0);
    chk("rst_inexact", 64'(inx_a), 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dir32("after_rst", 32'h12345678, 1'b0, 2'd0, 32'h4D91A2B4, 1'b1, 3);

    // Random 32-bit operands, checked by the scoreboard.
    for (int i = 0; i < 30; i++) begin
      go(0, $urandom, 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), k);
      waitd(0, k, lat);
    end

    // Narrow configuration: specials in every mode and signedness, then random.
    for (int i = 0; i < 5; i++)
      for (int md = 0; md < 4; md++)
        for (int sg = 0; sg < 2; sg++)
          run16(specials[i], 1'(sg), 2'(md));
    for (int i = 0; i < 200; i++)
      run16(16'($urandom), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)));

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
